// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcodes, MemRW codes,
// the decode NOP, FSM state codes and source-register usage decoders.
// Pure declarations; no logic or timing of its own.
package hazard_ctrl_pkg;

  // Base opcodes (id_instr[6:0])
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_BRA   = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  // ID/EX MemRW encodings
  localparam logic [1:0] MEMRW_LOAD  = 2'b10;
  localparam logic [1:0] MEMRW_STORE = 2'b01;

  // Value IF/ID is loaded with on a flush (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Sequencer states
  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LU    = 2'd1,
    HZ_MWAIT = 2'd2
  } hz_state_e;

  // Bundle of pipeline control outputs
  typedef struct packed {
    logic pc_keep;
    logic ifid_keep;
    logic ifid_flush;
    logic id_keep;
    logic id_nop;
    logic exmem_keep;
  } hz_ctrl_t;

  // rs1 is read by every known opcode except the U-type and JAL forms;
  // unknown opcodes read nothing so they can never cause a bubble.
  function automatic logic uses_rs1(input logic [6:0] op);
    logic u;
    u = 1'b0;
    case (op)
      OP_JALR, OP_LOAD, OP_ALUI, OP_BRA, OP_STORE, OP_R: u = 1'b1;
      default:                                           u = 1'b0;
    endcase
    return u;
  endfunction

  // rs2 is only read by branches, stores and register-register ALU ops.
  function automatic logic uses_rs2(input logic [6:0] op);
    logic u;
    u = 1'b0;
    case (op)
      OP_BRA, OP_STORE, OP_R: u = 1'b1;
      default:                u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Latency: count visible the cycle after the incrementing edge.
// No backpressure; inc is sampled every clock.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic sat;

  assign sat = &cnt;

  // Count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubble, taken-branch flush, data-memory freeze.
// Latency: controls are combinational from state and inputs (same cycle).
// Backpressure: a pending data access freezes PC, IF/ID, ID and EX/MEM/WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic [4:0]       ex_WReg,
  input  logic             ex_RegWrite,
  input  logic [1:0]       ex_MemRW,
  input  logic             ex_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_keep,
  output logic             ifid_keep,
  output logic             ifid_flush,
  output logic             id_keep,
  output logic             id_nop,
  output logic             exmem_keep,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter only needs to reach MEM_TO; it saturates there.
  localparam int               WCNT_W   = $clog2(MEM_TO + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MEM_TO);

  hz_state_e         state;
  hz_state_e         state_nxt;
  hz_ctrl_t          ctrl;
  logic              flush_ev;

  logic [6:0]        opcode;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              load_use;
  logic              mem_stall;

  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_inc;
  logic              timeout_q;

  // Instruction fields not involved in hazard detection
  logic              unused_bits;

  assign opcode      = id_instr[6:0];
  assign rs1         = id_instr[19:15];
  assign rs2         = id_instr[24:20];
  assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is never a real dependency.
  assign load_use = ex_RegWrite
                  & (ex_MemRW == MEMRW_LOAD)
                  & (ex_WReg != 5'd0)
                  & ((uses_rs1(opcode) & (rs1 == ex_WReg))
                   | (uses_rs2(opcode) & (rs2 == ex_WReg)));

  assign mem_stall = dmem_req & ~dmem_ready;

  // Next state and pipeline controls; priority is memory wait, then
  // taken redirect, then load-use. The bubble state only suppresses a
  // second load-use bubble; memory and redirect still act in it.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    flush_ev  = 1'b0;
    case (state)
      HZ_RUN, HZ_LU: begin
        if (mem_stall) begin
          ctrl.pc_keep    = 1'b1;
          ctrl.ifid_keep  = 1'b1;
          ctrl.id_keep    = 1'b1;
          ctrl.exmem_keep = 1'b1;
          state_nxt       = HZ_MWAIT;
        end else if (ex_taken) begin
          // The ID instruction is killed, so any load-use on it is moot.
          ctrl.id_nop     = 1'b1;
          ctrl.ifid_flush = 1'b1;
          flush_ev        = 1'b1;
          state_nxt       = HZ_RUN;
        end else if (load_use && (state == HZ_RUN)) begin
          ctrl.pc_keep    = 1'b1;
          ctrl.ifid_keep  = 1'b1;
          ctrl.id_nop     = 1'b1;
          state_nxt       = HZ_LU;
        end else begin
          state_nxt       = HZ_RUN;
        end
      end
      HZ_MWAIT: begin
        // EX is frozen, so ex_taken is left for after the wait.
        ctrl.pc_keep    = 1'b1;
        ctrl.ifid_keep  = 1'b1;
        ctrl.id_keep    = 1'b1;
        ctrl.exmem_keep = 1'b1;
        if (dmem_ready) begin
          state_nxt = HZ_RUN;
        end
      end
      default: begin
        state_nxt = HZ_RUN;
      end
    endcase
    // Controls read as idle for the whole time reset is held.
    if (!rst) begin
      ctrl     = '0;
      flush_ev = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HZ_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign wait_inc = (wait_cnt == WAIT_LIM) ? WAIT_LIM : wait_cnt + WCNT_W'(1);

  // Count consecutive wait cycles; raise the sticky timeout when the count
  // reaches MEM_TO. The counter clears on completion or outside the wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == HZ_MWAIT) begin
      wait_cnt <= dmem_ready ? '0 : wait_inc;
      if (wait_inc == WAIT_LIM) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign pc_keep     = ctrl.pc_keep;
  assign ifid_keep   = ctrl.ifid_keep;
  assign ifid_flush  = ctrl.ifid_flush;
  assign id_keep     = ctrl.id_keep;
  assign id_nop      = ctrl.id_nop;
  assign exmem_keep  = ctrl.exmem_keep;
  assign mem_timeout = timeout_q;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.pc_keep),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_ev),
    .cnt (flush_cnt)
  );

endmodule
